// File: rtl/decode_mux_stage.sv
// Decode mux stage: picks the lowest-index hitting format decoder, normalises its
// fields (immediate extend/shift, enable-gated fields) and queues the result in a small FIFO.
module decode_mux_stage #(
  parameter int NUM_CH    = 6,
  parameter int REG_W     = 5,
  parameter int IMM_IN_W  = 16,
  parameter int IMM_OUT_W = 64,
  parameter int XOP_W     = 10,
  parameter int FMT_W     = 5,
  parameter int FU_W      = 3,
  parameter int OPC_W     = 6,
  parameter int ADDR_W    = 64,
  parameter int DEPTH     = 2
) (
  input  logic                        clock_i,
  input  logic                        resetn_i,
  input  logic [ADDR_W-1:0]           instructionAddress_i,
  input  logic [OPC_W-1:0]            opcode_i,
  input  logic [NUM_CH-1:0]           chEnable_i,
  input  logic [NUM_CH*IMM_IN_W-1:0]  chImm_i,
  input  logic [NUM_CH-1:0]           chImmSigned_i,
  input  logic [NUM_CH*6-1:0]         chImmShift_i,
  input  logic [NUM_CH-1:0]           chImmEnable_i,
  input  logic [NUM_CH*3*REG_W-1:0]   chRegs_i,
  input  logic [NUM_CH*3-1:0]         chRegEnable_i,
  input  logic [NUM_CH*XOP_W-1:0]     chXop_i,
  input  logic [NUM_CH-1:0]           chXopEnable_i,
  input  logic [NUM_CH*FMT_W-1:0]     chFormat_i,
  input  logic [NUM_CH*FU_W-1:0]      chFu_i,
  input  logic [NUM_CH*2-1:0]         chBits_i,
  output logic                        ready_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [ADDR_W-1:0]           instructionAddress_o,
  output logic [OPC_W-1:0]            opcode_o,
  output logic [IMM_OUT_W-1:0]        imm_o,
  output logic                        immEnable_o,
  output logic [3*REG_W-1:0]          regs_o,
  output logic [2:0]                  regEnable_o,
  output logic [XOP_W-1:0]            xOpcode_o,
  output logic                        xOpcodeEnable_o,
  output logic [FMT_W-1:0]            format_o,
  output logic [FU_W-1:0]             fu_o,
  output logic [1:0]                  bits_o,
  output logic                        multiHit_o,
  output logic [7:0]                  multiHitCount_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [OPC_W-1:0]     opcode;
    logic [IMM_OUT_W-1:0] imm;
    logic                 imm_en;
    logic [3*REG_W-1:0]   regs;
    logic [2:0]           reg_en;
    logic [XOP_W-1:0]     xop;
    logic                 xop_en;
    logic [FMT_W-1:0]     fmt;
    logic [FU_W-1:0]      fu;
    logic [1:0]           bits;
  } entry_t;

  entry_t               sel_entry;
  entry_t               head;
  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 multi_hit_q, multi_hit_d;
  logic [7:0]           hit_cnt_q, hit_cnt_d;
  logic                 found;
  logic                 accept, pop, multi;
  logic [IMM_IN_W-1:0]  raw_imm;
  logic [IMM_OUT_W-1:0] ext_imm;
  logic [5:0]           shamt;

  // Loop runs high-to-low semantics via the found flag so channel 0 has top priority.
  always_comb begin
    sel_entry = '0;
    found     = 1'b0;
    raw_imm   = '0;
    ext_imm   = '0;
    shamt     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (chEnable_i[k] && !found) begin
        found   = 1'b1;
        raw_imm = chImm_i[k*IMM_IN_W +: IMM_IN_W];
        shamt   = chImmShift_i[k*6 +: 6];
        if (chImmSigned_i[k]) ext_imm = IMM_OUT_W'($signed(raw_imm));
        else                  ext_imm = IMM_OUT_W'(raw_imm);
        if (!chImmEnable_i[k] || (32'(shamt) >= IMM_OUT_W)) sel_entry.imm = '0;
        else                                                 sel_entry.imm = ext_imm << shamt;
        sel_entry.imm_en = chImmEnable_i[k];
        for (int r = 0; r < 3; r++) begin
          if (chRegEnable_i[k*3+r])
            sel_entry.regs[r*REG_W +: REG_W] = chRegs_i[(k*3+r)*REG_W +: REG_W];
        end
        sel_entry.reg_en = chRegEnable_i[k*3 +: 3];
        sel_entry.xop    = chXopEnable_i[k] ? chXop_i[k*XOP_W +: XOP_W] : '0;
        sel_entry.xop_en = chXopEnable_i[k];
        sel_entry.fmt    = chFormat_i[k*FMT_W +: FMT_W];
        sel_entry.fu     = chFu_i[k*FU_W +: FU_W];
        sel_entry.bits   = chBits_i[k*2 +: 2];
      end
    end
    sel_entry.addr   = instructionAddress_i;
    sel_entry.opcode = opcode_i;
  end

  assign ready_o = (count_q != CNT_W'(DEPTH));
  assign valid_o = (count_q != '0);
  assign accept  = (|chEnable_i) && ready_o;
  assign pop     = valid_o && ready_i;
  assign multi   = |(chEnable_i & (chEnable_i - NUM_CH'(1)));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      mem_d[wr_ptr_q] = sel_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (accept && !pop)      count_d = count_q + CNT_W'(1);
    else if (!accept && pop) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    multi_hit_d = multi_hit_q;
    hit_cnt_d   = hit_cnt_q;
    if (accept && multi) begin
      multi_hit_d = 1'b1;
      if (hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      multi_hit_q <= 1'b0;
      hit_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      multi_hit_q <= multi_hit_d;
      hit_cnt_q   <= hit_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clock_i) begin
    mem_q <= mem_d;
  end

  assign head = valid_o ? mem_q[rd_ptr_q] : '0;

  assign instructionAddress_o = head.addr;
  assign opcode_o             = head.opcode;
  assign imm_o                = head.imm;
  assign immEnable_o          = head.imm_en;
  assign regs_o               = head.regs;
  assign regEnable_o          = head.reg_en;
  assign xOpcode_o            = head.xop;
  assign xOpcodeEnable_o      = head.xop_en;
  assign format_o             = head.fmt;
  assign fu_o                 = head.fu;
  assign bits_o               = head.bits;
  assign multiHit_o           = multi_hit_q;
  assign multiHitCount_o      = hit_cnt_q;

endmodule
